// File: rtl/rom_sync_lut_pkg.sv
// Shared types and fixed contents for the rom_sync_lut constant table.
package rom_sync_lut_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int IDX_W  = 3;
  localparam int DEPTH  = 2 ** IDX_W;

  typedef logic [DATA_W-1:0] rom_word_t;
  typedef logic [IDX_W-1:0]  rom_idx_t;

  // Fixed table contents, index 0 first.
  localparam rom_word_t ROM_TABLE [DEPTH] = '{
    8'h3C, 8'hA5, 8'h0F, 8'hF0, 8'h55, 8'hAA, 8'h81, 8'h7E
  };

  // Every index is populated, so the lookup can never return X.
  function automatic rom_word_t rom_lookup(input rom_idx_t idx);
    return ROM_TABLE[idx];
  endfunction

endpackage

// File: rtl/rom_out_reg.sv
// DATA_W-wide output register with asynchronous active-high clear.
module rom_out_reg
  import rom_sync_lut_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Capture on every rising edge; reset clears immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/rom_sync_lut.sv
// Synchronous 8-entry constant lookup table with registered output.
// Only address[IDX_W-1:0] selects a word; upper address bits alias.
// Build option: define ROM_OUT_PIPE_EN for a second output register
// stage (2-cycle latency). Default build has 1-cycle latency.
module rom_sync_lut
  import rom_sync_lut_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data
);

  rom_idx_t  idx;
  rom_word_t lut_word;
  logic      unused_addr_hi;

  assign idx            = address[IDX_W-1:0];
  assign unused_addr_hi = ^address[ADDR_W-1:IDX_W];

  // Combinational table decode; maps to LUTs or a small ROM.
  always_comb begin
    lut_word = rom_lookup(idx);
  end

`ifdef ROM_OUT_PIPE_EN
  rom_word_t stage1;

  rom_out_reg u_out_reg0 (
    .clk (clk),
    .rst (rst),
    .d   (lut_word),
    .q   (stage1)
  );

  rom_out_reg u_out_reg1 (
    .clk (clk),
    .rst (rst),
    .d   (stage1),
    .q   (data)
  );
`else
  rom_out_reg u_out_reg0 (
    .clk (clk),
    .rst (rst),
    .d   (lut_word),
    .q   (data)
  );
`endif

endmodule

// File: tb/tb_rom_sync_lut.sv
// Self-checking bench for rom_sync_lut (both latency builds).
module tb_rom_sync_lut;

`ifdef ROM_OUT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] address;
  logic [7:0] data;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  rom_sync_lut dut (
    .clk     (clk),
    .rst     (rst),
    .address (address),
    .data    (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: word selected by address modulo 8.
  function automatic logic [7:0] ref_word(input int unsigned a);
    case (a % 8)
      0: return 8'h3C;
      1: return 8'hA5;
      2: return 8'h0F;
      3: return 8'hF0;
      4: return 8'h55;
      5: return 8'hAA;
      6: return 8'h81;
      default: return 8'h7E;
    endcase
  endfunction

  // Present one address, clock it in, and check the word due LAT edges after it.
  task automatic run_addr(input int unsigned a, input string name);
    logic [7:0] exp;
    address = a[7:0];
    @(posedge clk);
    #1;
    exp_q.push_back(ref_word(a));
    if (exp_q.size() >= LAT) begin
      exp = exp_q[exp_q.size() - LAT];
      total++;
      if (data !== exp) begin
        bad++;
        $display("FAIL %s addr=%0h got=%h want=%h", name, a[7:0], data, exp);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    address = 8'h01;
    #1;
    total++;
    if (data !== 8'h00) begin
      bad++;
      $display("FAIL reset_immediate got=%h want=00", data);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (data !== 8'h00) begin
        bad++;
        $display("FAIL reset_hold cycle=%0d got=%h want=00", i, data);
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (data !== ((i == LAT) ? 8'hA5 : 8'h00)) begin
        bad++;
        $display("FAIL reset_release edge=%0d got=%h want=%h", i, data,
                 (i == LAT) ? 8'hA5 : 8'h00);
      end
    end
  endtask

  task automatic test_sweep;
    exp_q.delete();
    for (int unsigned a = 0; a < 1024; a++) run_addr(a, "sweep");
  endtask

  task automatic test_alias;
    int unsigned alist[6] = '{32'h03, 32'h0B, 32'hFB, 32'hFF, 32'h08, 32'hF8};
    exp_q.delete();
    foreach (alist[i]) run_addr(alist[i], "alias");
    for (int i = 0; i < LAT - 1; i++) run_addr(32'h00, "alias_flush");
  endtask

  task automatic test_random;
    exp_q.delete();
    for (int i = 0; i < 200; i++) run_addr($urandom_range(0, 255), "random");
  endtask

  task automatic test_midstream_reset;
    exp_q.delete();
    run_addr(4, "mid_pre");
    run_addr(5, "mid_pre");
    run_addr(6, "mid_pre");
    #2 rst = 1'b1;
    #1;
    total++;
    if (data !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset_clear got=%h want=00", data);
    end
    #2 rst = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (data !== ((i == LAT) ? 8'h81 : 8'h00)) begin
        bad++;
        $display("FAIL mid_reset_resume edge=%0d got=%h want=%h", i, data,
                 (i == LAT) ? 8'h81 : 8'h00);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_q.delete();
    for (int i = 0; i < LAT; i++) run_addr(2, "b2b_prime");
    run_addr(0, "b2b");
    run_addr(7, "b2b");
    run_addr(0, "b2b");
    for (int i = 0; i < LAT - 1; i++) run_addr(0, "b2b_flush");
  endtask

  task automatic test_glitch;
    logic [7:0] held;
    exp_q.delete();
    for (int i = 0; i < LAT; i++) run_addr(5, "glitch_prime");
    held = data;
    address = 8'h00;
    #2 address = 8'h07;
    #2;
    total++;
    if (data !== held) begin
      bad++;
      $display("FAIL glitch_hold got=%h want=%h", data, held);
    end
    total++;
    if (held !== 8'hAA) begin
      bad++;
      $display("FAIL glitch_base got=%h want=AA", held);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_alias();
    test_random();
    test_midstream_reset();
    test_back_to_back();
    test_glitch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
